// File: rtl/ext_bus_pkg.sv
// Shared types and helpers for the external-bus arbiter.
//   state_e   : arbiter FSM states
//   ARB_RR    : round-robin arbitration mode
//   ARB_FIXED : fixed-priority arbitration mode (index 0 highest)
//   gid_width : width of a master index, never less than 1 bit
package ext_bus_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  function automatic int unsigned gid_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ext_bus_grant.sv
// Combinational grant logic for the external-bus arbiter.
//   req_i         : request vector (already masked by the caller)
//   rr_ptr_i      : round-robin start index (unused in fixed-priority mode)
//   grant_o       : one-hot grant, all zero when nothing is requested
//   grant_idx_o   : index of the granted master
//   grant_valid_o : at least one request present
module ext_bus_grant
  import ext_bus_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ARB_MODE  = ARB_RR
) (
  input  logic [N_MASTERS-1:0]                req_i,
  input  logic [gid_width(N_MASTERS)-1:0]     rr_ptr_i,
  output logic [N_MASTERS-1:0]                grant_o,
  output logic [gid_width(N_MASTERS)-1:0]     grant_idx_o,
  output logic                                grant_valid_o
);

  localparam int unsigned GidW = gid_width(N_MASTERS);

  logic [N_MASTERS-1:0] hi_mask;
  logic [N_MASTERS-1:0] req_hi;
  logic [N_MASTERS-1:0] sel;

  // Round-robin search: prefer requesters at or above the pointer, otherwise wrap
  // around to the lowest requester. Fixed priority simply takes the lowest index.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      hi_mask[i] = (GidW'(i) >= rr_ptr_i);
    end
    req_hi = req_i & hi_mask;

    if (ARB_MODE == ARB_FIXED) begin
      sel = req_i;
    end else begin
      sel = (|req_hi) ? req_hi : req_i;
    end
  end

  always_comb begin
    grant_idx_o   = '0;
    grant_o       = '0;
    grant_valid_o = |req_i;
    // Descending scan so the lowest set bit of sel is the last write.
    for (int i = int'(N_MASTERS) - 1; i >= 0; i--) begin
      if (sel[i]) begin
        grant_idx_o = GidW'(i);
      end
    end
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      grant_o[i] = grant_valid_o && (grant_idx_o == GidW'(i));
    end
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// N-master to 1-slave arbiter for the external-bus bridge protocol.
//   clk_clk / reset_reset_n          : clock, asynchronous active-low reset
//   m_bus_enable, m_rw, m_address,
//   m_byte_enable, m_write_data      : per-master request fields (flattened)
//   m_read_data                      : per-master registered read data
//   m_acknowledge                    : one-cycle completion pulse per master
//   m_irq                            : slave interrupt fanned out to every master
//   s_bus_enable, s_rw, s_address,
//   s_byte_enable, s_write_data      : registered request towards the slave
//   s_read_data, s_acknowledge, s_irq: slave response
//   err_clear / bus_error            : sticky timeout flag and its clear
//   grant_id                         : index of the current or last winner
module ext_bus_arbiter
  import ext_bus_pkg::*;
#(
  parameter int unsigned       N_MASTERS = 2,
  parameter int unsigned       ADDR_W    = 11,
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ARB_MODE  = ARB_RR,
  parameter int unsigned       TIMEOUT   = 255,
  parameter logic [DATA_W-1:0] ERR_DATA  = 16'hDEAD
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset_n,
  input  logic [N_MASTERS-1:0]            m_bus_enable,
  input  logic [N_MASTERS-1:0]            m_rw,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_address,
  input  logic [N_MASTERS*(DATA_W/8)-1:0] m_byte_enable,
  input  logic [N_MASTERS*DATA_W-1:0]     m_write_data,
  output logic [N_MASTERS*DATA_W-1:0]     m_read_data,
  output logic [N_MASTERS-1:0]            m_acknowledge,
  output logic [N_MASTERS-1:0]            m_irq,
  output logic                            s_bus_enable,
  output logic                            s_rw,
  output logic [ADDR_W-1:0]               s_address,
  output logic [DATA_W/8-1:0]             s_byte_enable,
  output logic [DATA_W-1:0]               s_write_data,
  input  logic [DATA_W-1:0]               s_read_data,
  input  logic                            s_acknowledge,
  input  logic                            s_irq,
  input  logic                            err_clear,
  output logic                            bus_error,
  output logic [gid_width(N_MASTERS)-1:0] grant_id
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned GidW = gid_width(N_MASTERS);
  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e state_q, state_d;

  logic [GidW-1:0]            win_q;
  logic [GidW-1:0]            rr_ptr_q;
  logic [CntW-1:0]            cnt_q;
  logic                       mask_q;
  logic                       bus_error_q;
  logic                       s_rw_q;
  logic [ADDR_W-1:0]          s_address_q;
  logic [BE_W-1:0]            s_byte_enable_q;
  logic [DATA_W-1:0]          s_write_data_q;
  logic [N_MASTERS*DATA_W-1:0] rdata_q;

  logic [N_MASTERS-1:0] win_onehot;
  logic [N_MASTERS-1:0] req_masked;
  logic [N_MASTERS-1:0] gnt_onehot;
  logic [GidW-1:0]      gnt_idx;
  logic                 gnt_valid;
  logic                 timeout_hit;
  logic                 busy_end;
  logic                 start;

  logic                 sel_rw;
  logic [ADDR_W-1:0]    sel_address;
  logic [BE_W-1:0]      sel_byte_enable;
  logic [DATA_W-1:0]    sel_write_data;

  // ---------------------------------------------------------------------------
  // Request masking and grant
  // ---------------------------------------------------------------------------
  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      win_onehot[i] = (win_q == GidW'(i));
    end
  end

  // The master that just completed may still show bus_enable in the cycle after
  // its ack; hide it for that one cycle so it cannot be re-served by accident.
  // Fixed priority deliberately skips this so the top master keeps the bus.
  always_comb begin
    req_masked = m_bus_enable;
    if (mask_q && (ARB_MODE == ARB_RR)) begin
      req_masked = m_bus_enable & ~win_onehot;
    end
  end

  ext_bus_grant #(
    .N_MASTERS(N_MASTERS),
    .ARB_MODE (ARB_MODE)
  ) u_grant (
    .req_i        (req_masked),
    .rr_ptr_i     (rr_ptr_q),
    .grant_o      (gnt_onehot),
    .grant_idx_o  (gnt_idx),
    .grant_valid_o(gnt_valid)
  );

  // One-hot AND-OR mux of the winner's request fields.
  always_comb begin
    sel_rw          = 1'b0;
    sel_address     = '0;
    sel_byte_enable = '0;
    sel_write_data  = '0;
    for (int i = 0; i < int'(N_MASTERS); i++) begin
      if (gnt_onehot[i]) begin
        sel_rw          |= m_rw[i];
        sel_address     |= m_address[i*ADDR_W +: ADDR_W];
        sel_byte_enable |= m_byte_enable[i*BE_W +: BE_W];
        sel_write_data  |= m_write_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));
  assign start       = (state_q == StIdle) && gnt_valid;
  assign busy_end    = (state_q == StBusy) && (s_acknowledge || timeout_hit);

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_valid) state_d = StBusy;
      StBusy:  if (s_acknowledge || timeout_hit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_bus_enable  = 1'b0;
    m_acknowledge = '0;
    unique case (state_q)
      StBusy:  s_bus_enable  = 1'b1;
      StDone:  m_acknowledge = win_onehot;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      win_q           <= '0;
      s_rw_q          <= 1'b0;
      s_address_q     <= '0;
      s_byte_enable_q <= '0;
      s_write_data_q  <= '0;
    end else if (start) begin
      win_q           <= gnt_idx;
      s_rw_q          <= sel_rw;
      s_address_q     <= sel_address;
      s_byte_enable_q <= sel_byte_enable;
      s_write_data_q  <= sel_write_data;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (state_q == StBusy) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mask_q   <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      mask_q <= (state_q == StDone);
      if ((state_q == StDone) && (ARB_MODE == ARB_RR)) begin
        rr_ptr_q <= (win_q == GidW'(N_MASTERS - 1)) ? '0 : win_q + GidW'(1);
      end
    end
  end

  // Read data is captured on writes too; an ack in the terminal-count cycle
  // still delivers real data.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rdata_q <= '0;
    end else if (busy_end) begin
      for (int i = 0; i < int'(N_MASTERS); i++) begin
        if (win_onehot[i]) begin
          rdata_q[i*DATA_W +: DATA_W] <= s_acknowledge ? s_read_data : ERR_DATA;
        end
      end
    end
  end

  // Set has priority over clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bus_error_q <= 1'b0;
    end else if (busy_end && !s_acknowledge) begin
      bus_error_q <= 1'b1;
    end else if (err_clear) begin
      bus_error_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_rw          = s_rw_q;
  assign s_address     = s_address_q;
  assign s_byte_enable = s_byte_enable_q;
  assign s_write_data  = s_write_data_q;
  assign m_read_data   = rdata_q;
  assign bus_error     = bus_error_q;
  assign grant_id      = win_q;
  // Gated so every output reads zero while reset is held.
  assign m_irq         = reset_reset_n ? {N_MASTERS{s_irq}} : '0;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
module tb_ext_bus_arbiter;

  typedef struct {
    int          idx;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t exp_c[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- DUT a: N=2, round-robin, TIMEOUT=8 ----------------
  logic        rst_a;
  logic [1:0]  a_en = '0, a_rw = '0, a_hold = '0, a_ack, a_irq;
  logic [21:0] a_addr = '0;
  logic [3:0]  a_be = '0;
  logic [31:0] a_wd = '0, a_rd;
  logic        a_sen, a_srw, a_sack = 1'b0, a_sirq = 1'b0, a_eclr = 1'b0, a_err;
  logic [10:0] a_saddr;
  logic [1:0]  a_sbe;
  logic [15:0] a_swd, a_srd = '0;
  logic [0:0]  a_gid;
  int          a_ack_at = 0, a_bcnt = 0;

  ext_bus_arbiter #(
    .N_MASTERS(2), .ADDR_W(11), .DATA_W(16), .ARB_MODE(0), .TIMEOUT(8), .ERR_DATA(16'hDEAD)
  ) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_a), .m_bus_enable(a_en), .m_rw(a_rw),
    .m_address(a_addr), .m_byte_enable(a_be), .m_write_data(a_wd), .m_read_data(a_rd),
    .m_acknowledge(a_ack), .m_irq(a_irq), .s_bus_enable(a_sen), .s_rw(a_srw),
    .s_address(a_saddr), .s_byte_enable(a_sbe), .s_write_data(a_swd), .s_read_data(a_srd),
    .s_acknowledge(a_sack), .s_irq(a_sirq), .err_clear(a_eclr), .bus_error(a_err),
    .grant_id(a_gid)
  );

  // ---------------- DUT b: N=2, fixed priority, TIMEOUT=8 ----------------
  logic        rst_n;
  logic [1:0]  b_en = '0, b_rw = '0, b_hold = '0, b_ack, b_irq;
  logic [21:0] b_addr = '0;
  logic [3:0]  b_be = '0;
  logic [31:0] b_wd = '0, b_rd;
  logic        b_sen, b_srw, b_sack = 1'b0, b_err;
  logic [10:0] b_saddr;
  logic [1:0]  b_sbe;
  logic [15:0] b_swd, b_srd = '0;
  logic [0:0]  b_gid;
  int          b_ack_at = 0, b_bcnt = 0;

  ext_bus_arbiter #(
    .N_MASTERS(2), .ADDR_W(11), .DATA_W(16), .ARB_MODE(1), .TIMEOUT(8), .ERR_DATA(16'hDEAD)
  ) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .m_bus_enable(b_en), .m_rw(b_rw),
    .m_address(b_addr), .m_byte_enable(b_be), .m_write_data(b_wd), .m_read_data(b_rd),
    .m_acknowledge(b_ack), .m_irq(b_irq), .s_bus_enable(b_sen), .s_rw(b_srw),
    .s_address(b_saddr), .s_byte_enable(b_sbe), .s_write_data(b_swd), .s_read_data(b_srd),
    .s_acknowledge(b_sack), .s_irq(1'b0), .err_clear(1'b0), .bus_error(b_err),
    .grant_id(b_gid)
  );

  // ---------------- DUT c: N=4, round-robin, TIMEOUT=8 ----------------
  logic [3:0]  c_en = '0, c_rw = '0, c_ack, c_irq;
  logic [43:0] c_addr = '0;
  logic [7:0]  c_be = '0;
  logic [63:0] c_wd = '0, c_rd;
  logic        c_sen, c_srw, c_sack = 1'b0, c_sirq = 1'b0, c_err;
  logic [10:0] c_saddr;
  logic [1:0]  c_sbe;
  logic [15:0] c_swd, c_srd = '0;
  logic [1:0]  c_gid;
  int          c_ack_at = 0, c_bcnt = 0;

  ext_bus_arbiter #(
    .N_MASTERS(4), .ADDR_W(11), .DATA_W(16), .ARB_MODE(0), .TIMEOUT(8), .ERR_DATA(16'hDEAD)
  ) dut_c (
    .clk_clk(clk), .reset_reset_n(rst_n), .m_bus_enable(c_en), .m_rw(c_rw),
    .m_address(c_addr), .m_byte_enable(c_be), .m_write_data(c_wd), .m_read_data(c_rd),
    .m_acknowledge(c_ack), .m_irq(c_irq), .s_bus_enable(c_sen), .s_rw(c_srw),
    .s_address(c_saddr), .s_byte_enable(c_sbe), .s_write_data(c_swd), .s_read_data(c_srd),
    .s_acknowledge(c_sack), .s_irq(c_sirq), .err_clear(1'b0), .bus_error(c_err),
    .grant_id(c_gid)
  );

  // Slave responders (ack in the ack_at-th enable cycle, 0 = never) and masters that
  // drop their request once acked unless told to hold it.
  initial forever begin
    @(negedge clk);
    a_bcnt = a_sen ? a_bcnt + 1 : 0;
    a_sack = a_sen && (a_bcnt == a_ack_at);
    b_bcnt = b_sen ? b_bcnt + 1 : 0;
    b_sack = b_sen && (b_bcnt == b_ack_at);
    c_bcnt = c_sen ? c_bcnt + 1 : 0;
    c_sack = c_sen && (c_bcnt == c_ack_at);
    a_en = a_en & ~(a_ack & ~a_hold);
    b_en = b_en & ~(b_ack & ~b_hold);
    c_en = c_en & ~c_ack;
  end

  // Scoreboard monitors: pop one expected completion per m_acknowledge pulse.
  initial begin : mon_a
    exp_t e;
    forever begin
      @(negedge clk);
      if (|a_ack) begin
        if (exp_a.size() == 0) chk("a_unexpected_ack", 32'(a_ack), 32'd0);
        else begin
          e = exp_a.pop_front();
          chk("a_ack_onehot", 32'(a_ack), 32'd1 << e.idx);
          chk("a_grant_id", 32'(a_gid), 32'(e.idx));
          chk("a_read_data", 32'(a_rd[e.idx*16 +: 16]), 32'(e.rdata));
          chk("a_bus_error", 32'(a_err), 32'(e.err));
        end
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (|b_ack) begin
        if (exp_b.size() == 0) chk("b_unexpected_ack", 32'(b_ack), 32'd0);
        else begin
          e = exp_b.pop_front();
          chk("b_ack_onehot", 32'(b_ack), 32'd1 << e.idx);
          chk("b_grant_id", 32'(b_gid), 32'(e.idx));
          chk("b_read_data", 32'(b_rd[e.idx*16 +: 16]), 32'(e.rdata));
        end
      end
    end
  end

  initial begin : mon_c
    exp_t e;
    forever begin
      @(negedge clk);
      if (|c_ack) begin
        if (exp_c.size() == 0) chk("c_unexpected_ack", 32'(c_ack), 32'd0);
        else begin
          e = exp_c.pop_front();
          chk("c_ack_onehot", 32'(c_ack), 32'd1 << e.idx);
          chk("c_grant_id", 32'(c_gid), 32'(e.idx));
          chk("c_read_data", 32'(c_rd[e.idx*16 +: 16]), 32'(e.rdata));
          chk("c_bus_error", 32'(c_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int acks;
    int guard;
    rst_a = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_s_bus_enable", 32'(a_sen), 32'd0);
    chk("rst_m_ack", 32'(a_ack), 32'd0);
    chk("rst_grant_id", 32'(a_gid), 32'd0);
    chk("rst_bus_error", 32'(a_err), 32'd0);
    chk("rst_read_data", a_rd, 32'd0);
    rst_a = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: master 0 write, ack in 4th enable cycle
    a_addr[10:0] = 11'h155; a_wd[15:0] = 16'hA5A5; a_be[1:0] = 2'b11; a_rw[0] = 1'b0;
    a_ack_at = 4; a_srd = 16'h0F0F;
    exp_a.push_back('{0, 16'h0F0F, 1'b0});
    a_en[0] = 1'b1;
    @(negedge clk);
    chk("t1_latency", 32'(a_sen), 32'd1);
    chk("t1_s_rw", 32'(a_srw), 32'd0);
    chk("t1_s_address", 32'(a_saddr), 32'h155);
    chk("t1_s_byte_enable", 32'(a_sbe), 32'h3);
    chk("t1_s_write_data", 32'(a_swd), 32'hA5A5);
    cnt = 0;
    while (a_sen && cnt < 20) begin cnt++; @(negedge clk); end
    chk("t1_enable_cycles", 32'(cnt), 32'd4);
    chk("t1_ack_pulse", 32'(a_ack), 32'h1);
    @(negedge clk);
    chk("t1_ack_single", 32'(a_ack), 32'h0);
    chk("t1_bus_error", 32'(a_err), 32'd0);
    repeat (2) @(negedge clk);

    // Test 4: master 1 read, slave never acks -> timeout after 8 BUSY cycles
    a_addr[21:11] = 11'h2AA; a_rw[1] = 1'b1; a_ack_at = 0;
    exp_a.push_back('{1, 16'hDEAD, 1'b1});
    a_en[1] = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (a_sen && cnt < 30) begin cnt++; @(negedge clk); end
    chk("t4_busy_cycles", 32'(cnt), 32'd8);
    chk("t4_ack_pulse", 32'(a_ack), 32'h2);
    repeat (4) @(negedge clk);
    chk("t4_error_sticky", 32'(a_err), 32'd1);
    chk("t4_read_data_hold", 32'(a_rd[31:16]), 32'hDEAD);
    a_eclr = 1'b1;
    @(negedge clk);
    a_eclr = 1'b0;
    chk("t4_error_cleared", 32'(a_err), 32'd0);

    // Test 2: round-robin with both masters requesting continuously
    a_ack_at = 2; a_srd = 16'h1111;
    exp_a.push_back('{0, 16'h1111, 1'b0});
    exp_a.push_back('{1, 16'h1111, 1'b0});
    exp_a.push_back('{0, 16'h1111, 1'b0});
    exp_a.push_back('{1, 16'h1111, 1'b0});
    a_hold = 2'b11; a_en = 2'b11;
    acks = 0; guard = 0;
    while (acks < 4 && guard < 100) begin
      @(negedge clk); guard++;
      if (|a_ack) acks++;
    end
    a_hold = 2'b00; a_en = 2'b00;
    chk("t2_ack_count", 32'(acks), 32'd4);
    repeat (3) @(negedge clk);

    // Test 5: reset while BUSY (master 1), then first grant comes from master 0
    a_ack_at = 0;
    a_en[1] = 1'b1;
    guard = 0;
    while (!a_sen && guard < 20) begin @(negedge clk); guard++; end
    chk("t5_started", 32'(a_sen), 32'd1);
    @(negedge clk);
    rst_a = 1'b0;
    a_en = 2'b00;
    #1;
    chk("t5_rst_s_bus_enable", 32'(a_sen), 32'd0);
    chk("t5_rst_grant_id", 32'(a_gid), 32'd0);
    chk("t5_rst_s_address", 32'(a_saddr), 32'd0);
    chk("t5_rst_read_data", a_rd, 32'd0);
    chk("t5_rst_m_ack", 32'(a_ack), 32'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    a_ack_at = 2; a_srd = 16'h5A5A;
    exp_a.push_back('{0, 16'h5A5A, 1'b0});
    exp_a.push_back('{1, 16'h5A5A, 1'b0});
    a_en = 2'b11;
    @(negedge clk);
    chk("t5_first_grant", 32'(a_gid), 32'd0);
    acks = 0; guard = 0;
    while (acks < 2 && guard < 50) begin
      @(negedge clk); guard++;
      if (|a_ack) acks++;
    end
    chk("t5_ack_count", 32'(acks), 32'd2);

    // Test 3: fixed priority starves master 1 until master 0 lets go
    b_ack_at = 2; b_srd = 16'h2222;
    exp_b.push_back('{0, 16'h2222, 1'b0});
    exp_b.push_back('{0, 16'h2222, 1'b0});
    exp_b.push_back('{0, 16'h2222, 1'b0});
    exp_b.push_back('{1, 16'h2222, 1'b0});
    b_hold = 2'b11; b_en = 2'b11;
    acks = 0; guard = 0;
    while (acks < 3 && guard < 100) begin
      @(negedge clk); guard++;
      if (|b_ack) acks++;
    end
    b_hold = 2'b00; b_en[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_m1_granted", 32'(b_sen), 32'd1);
    chk("t3_m1_grant_id", 32'(b_gid), 32'd1);
    guard = 0;
    while (b_ack == '0 && guard < 20) begin @(negedge clk); guard++; end
    chk("t3_m1_acked", 32'(b_ack), 32'h2);
    repeat (2) @(negedge clk);

    // Test 6: N=4, ack arrives on the terminal-count cycle -> real data, no error
    c_addr[32:22] = 11'h7FF; c_rw[2] = 1'b1; c_ack_at = 8; c_srd = 16'h1234;
    exp_c.push_back('{2, 16'h1234, 1'b0});
    c_en[2] = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (c_sen && cnt < 30) begin cnt++; @(negedge clk); end
    chk("t6_busy_cycles", 32'(cnt), 32'd8);
    @(negedge clk);
    chk("t6_bus_error", 32'(c_err), 32'd0);
    chk("t6_read_data_hold", 32'(c_rd[47:32]), 32'h1234);
    c_sirq = 1'b1;
    #1;
    chk("t6_irq_high", 32'(c_irq), 32'hF);
    c_sirq = 1'b0;
    #1;
    chk("t6_irq_low", 32'(c_irq), 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_a_drained", 32'(exp_a.size()), 32'd0);
    chk("sb_b_drained", 32'(exp_b.size()), 32'd0);
    chk("sb_c_drained", 32'(exp_c.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
